// File: rtl/add_n_pipe.sv
// add_n_pipe: pipelined two's-complement adder/subtractor with valid/ready
// handshakes on both sides. The carry chain is cut into STAGES chunks of
// C = WIDTH/STAGES bits. Each stage adds one chunk and registers the carry for
// the next stage, so the block accepts one operation per cycle at any WIDTH.
// WIDTH must be a multiple of STAGES, and STAGES must be at least 1.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; drops all in-flight beats
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (equals the global advance)
//   a, b       operands
//   cin        carry-in; ignored when sub=1
//   sub        0: a+b+cin, 1: a-b computed as a+~b+1
//   out_valid  result present
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (for sub, 1 = no borrow)
//   overflow   signed overflow
//   zero       sum == 0
module add_n_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int C = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  // One stall signal for the whole pipe: bubbles are not collapsed.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign bx       = sub ? ~b : b;
  assign c0       = sub | cin;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int DONE = (s + 1) * C;   // low sum bits finished after this stage
    localparam int REM  = WIDTH - DONE;  // operand bits still waiting to be added

    logic            vld;
    logic            cy;
    logic            sa;
    logic            sb;
    logic [DONE-1:0] acc;

    logic            nxt_v;
    logic            ci;
    logic            nxt_sa;
    logic            nxt_sb;
    logic [C-1:0]    ca;
    logic [C-1:0]    cb;
    logic [C:0]      csum;
    logic [DONE-1:0] nxt_acc;

    if (s == 0) begin : g_first
      assign nxt_v   = in_valid;
      assign ca      = a[C-1:0];
      assign cb      = bx[C-1:0];
      assign ci      = c0;
      assign nxt_sa  = a[WIDTH-1];
      assign nxt_sb  = bx[WIDTH-1];
      assign nxt_acc = csum[C-1:0];
    end else begin : g_next
      // Pending operand bits are kept right-aligned, so the next chunk is
      // always at the bottom of the previous stage's remainder.
      assign nxt_v   = g_stage[s-1].vld;
      assign ca      = g_stage[s-1].g_rem.rem_a[C-1:0];
      assign cb      = g_stage[s-1].g_rem.rem_b[C-1:0];
      assign ci      = g_stage[s-1].cy;
      assign nxt_sa  = g_stage[s-1].sa;
      assign nxt_sb  = g_stage[s-1].sb;
      assign nxt_acc = {csum[C-1:0], g_stage[s-1].acc};
    end

    assign csum = {1'b0, ca} + {1'b0, cb} + {{C{1'b0}}, ci};

    // Data registers are cleared too so the outputs read sum=0/zero=1 after reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld <= 1'b0;
        cy  <= 1'b0;
        sa  <= 1'b0;
        sb  <= 1'b0;
        acc <= '0;
      end else if (adv) begin
        vld <= nxt_v;
        cy  <= csum[C];
        sa  <= nxt_sa;
        sb  <= nxt_sb;
        acc <= nxt_acc;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] rem_a;
      logic [REM-1:0] rem_b;
      logic [REM-1:0] nxt_rem_a;
      logic [REM-1:0] nxt_rem_b;

      if (s == 0) begin : g_src_in
        assign nxt_rem_a = a[WIDTH-1:C];
        assign nxt_rem_b = bx[WIDTH-1:C];
      end else begin : g_src_prev
        assign nxt_rem_a = g_stage[s-1].g_rem.rem_a[REM+C-1:C];
        assign nxt_rem_b = g_stage[s-1].g_rem.rem_b[REM+C-1:C];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rem_a <= '0;
          rem_b <= '0;
        end else if (adv) begin
          rem_a <= nxt_rem_a;
          rem_b <= nxt_rem_b;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld;
  assign sum       = g_stage[STAGES-1].acc;
  assign cout      = g_stage[STAGES-1].cy;
  // Signed overflow: operand signs agree (after inverting b for sub) but the
  // result sign does not.
  assign overflow  = (g_stage[STAGES-1].sa == g_stage[STAGES-1].sb) &&
                     (sum[WIDTH-1] != g_stage[STAGES-1].sa);
  assign zero      = (sum == '0);

endmodule

// File: tb/tb_add_n_pipe.sv
// tb_add_n_pipe: scoreboard bench for add_n_pipe. A 16-bit/4-stage instance
// runs directed vectors, backpressure and mid-flight reset; three more
// instances (8/1, 32/8, 16/16) stream random beats against a reference model.
module tb_add_n_pipe;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          issue;
    bit          chk_lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic clk;
  logic reset;
  logic rst_sw;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pop = 0;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic        cout, overflow, zero;
  logic [15:0] a, b, sum;

  exp_t q[$];
  exp_t me;
  bit   stall_prev = 0;
  vec_t vecs[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_n_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow),
    .zero(zero)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail(input string nm, input string detail);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
  endtask

  function automatic exp_t model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mcin, input logic msub);
    exp_t e;
    logic [63:0] mask, bxx, full;
    logic sa, sb, ss;
    mask   = (64'd1 << w) - 64'd1;
    bxx    = (msub ? ~{32'd0, mb} : {32'd0, mb}) & mask;
    full   = ({32'd0, ma} & mask) + bxx + (msub ? 64'd1 : {63'd0, mcin});
    e.sum  = 32'(full & mask);
    e.cout = full[w];
    sa     = ma[w-1];
    sb     = bxx[w-1];
    ss     = e.sum[w-1];
    e.ovf  = (sa == sb) && (ss != sa);
    e.zero = (e.sum == 32'd0);
    e.issue = 0;
    e.chk_lat = 1'b1;
    return e;
  endfunction

  function automatic exp_t vec_exp(input vec_t v);
    exp_t e;
    e.sum = {16'd0, v.sum};
    e.cout = v.cout;
    e.ovf = v.ovf;
    e.zero = v.zero;
    e.issue = 0;
    e.chk_lat = 1'b1;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [15:0] ta, input logic [15:0] tbv, input logic tcin,
                      input logic tsub, input exp_t e, input bit lat);
    int  tries = 0;
    bit  done = 0;
    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1;
    while (!done) begin
      #1;
      if (in_ready) begin
        e.issue = cyc;
        e.chk_lat = lat;
        q.push_back(e);
        done = 1;
      end else if (tries > 50) begin
        fail("send_accept", "in_ready never rose, required 1");
        done = 1;
      end
      tries++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int i = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("drain_pending", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  // Main scoreboard monitor: samples 2 time units after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) check("stall_out_valid", {63'd0, out_valid}, 64'd1);
        if (out_valid) begin
          if (q.size() == 0) begin
            fail("unexpected_result", $sformatf("out_valid=1 sum=%h, required no result", sum));
          end else begin
            me = q[0];
            check("sum", {48'd0, sum}, {32'd0, me.sum});
            check("cout", {63'd0, cout}, {63'd0, me.cout});
            check("overflow", {63'd0, overflow}, {63'd0, me.ovf});
            check("zero", {63'd0, zero}, {63'd0, me.zero});
            if (!out_ready) begin
              check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            end else begin
              void'(q.pop_front());
              n_pop++;
              if (me.chk_lat) check("latency", 64'(cyc - me.issue), 64'd4);
            end
          end
        end
        stall_prev = out_valid && !out_ready;
      end
    end
  end

  // Parameter sweep instances, free-running with out_ready held high.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 32 : 16);
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 8 : 16);

    logic         iv, ir, s_cin, s_sub, ov, co, ovf, zr;
    logic [W-1:0] s_a, s_b, s_sum;
    exp_t         sq[$];
    exp_t         se;
    bit           done = 0;

    add_n_pipe #(.WIDTH(W), .STAGES(S)) dut_sw (
      .clk(clk), .reset(rst_sw), .in_valid(iv), .in_ready(ir),
      .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(ov),
      .out_ready(1'b1), .sum(s_sum), .cout(co), .overflow(ovf), .zero(zr)
    );

    initial begin
      int sent = 0;
      int iter = 0;
      exp_t e;
      iv = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      @(negedge clk);
      while (rst_sw) @(negedge clk);
      while (sent < 1000 && iter < 5000) begin
        @(negedge clk);
        iv    = ($urandom_range(3) != 0);
        s_a   = W'($urandom);
        s_b   = W'($urandom);
        s_cin = 1'($urandom);
        s_sub = 1'($urandom);
        #1;
        if (iv && ir) begin
          e = model(W, 32'(s_a), 32'(s_b), s_cin, s_sub);
          e.issue = cyc;
          sq.push_back(e);
          sent++;
        end
        iter++;
      end
      @(negedge clk);
      iv = 1'b0;
      for (int i = 0; i < 100 && sq.size() != 0; i++) @(negedge clk);
      check($sformatf("sweep%0d_drain", W), 64'(sq.size()), 64'd0);
      done = 1;
    end

    initial begin
      forever begin
        @(negedge clk);
        #2;
        if (!rst_sw && ov) begin
          if (sq.size() == 0) begin
            fail($sformatf("sweep%0d_unexpected", W), "out_valid=1, required no result");
          end else begin
            se = sq.pop_front();
            check($sformatf("sweep%0d_sum", W), 64'(s_sum), {32'd0, se.sum});
            check($sformatf("sweep%0d_cout", W), {63'd0, co}, {63'd0, se.cout});
            check($sformatf("sweep%0d_ovf", W), {63'd0, ovf}, {63'd0, se.ovf});
            check($sformatf("sweep%0d_zero", W), {63'd0, zr}, {63'd0, se.zero});
            check($sformatf("sweep%0d_latency", W), 64'(cyc - se.issue), 64'(S));
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] bp_a[8], bp_b[8];
    logic        bp_cin[8], bp_sub[8];
    int          pop0;
    int          i;

    vecs[0]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h3CC3, 16'h0FF0, 1'b0, 1'b0, 16'h4CB3, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h1234, 16'h9876, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; rst_sw = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_sum", {48'd0, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    reset = 1'b0; rst_sw = 1'b0;
    @(negedge clk);

    // Back-to-back stream, then flag and subtract vectors.
    for (i = 0; i < 3; i++) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vec_exp(vecs[i]), 1'b1);
    drain();
    for (i = 3; i < 12; i++) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vec_exp(vecs[i]), 1'b1);
    drain();

    // Backpressure: 5-cycle stall after 6 beats, beat 6 presented throughout.
    for (i = 0; i < 8; i++) begin
      bp_a[i] = 16'($urandom); bp_b[i] = 16'($urandom);
      bp_cin[i] = 1'($urandom); bp_sub[i] = 1'($urandom);
    end
    pop0 = n_pop;
    for (i = 0; i < 6; i++)
      send(bp_a[i], bp_b[i], bp_cin[i], bp_sub[i], model(16, {16'd0, bp_a[i]}, {16'd0, bp_b[i]}, bp_cin[i], bp_sub[i]), 1'b0);
    out_ready = 1'b0;
    a = bp_a[6]; b = bp_b[6]; cin = bp_cin[6]; sub = bp_sub[6]; in_valid = 1'b1;
    repeat (5) begin
      #1;
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (i = 6; i < 8; i++)
      send(bp_a[i], bp_b[i], bp_cin[i], bp_sub[i], model(16, {16'd0, bp_a[i]}, {16'd0, bp_b[i]}, bp_cin[i], bp_sub[i]), 1'b0);
    drain();
    check("bp_result_count", 64'(n_pop - pop0), 64'd8);

    // Reset with three beats in flight; the oldest is at the output.
    for (i = 0; i < 3; i++)
      send(bp_a[i], bp_b[i], bp_cin[i], bp_sub[i], model(16, {16'd0, bp_a[i]}, {16'd0, bp_b[i]}, bp_cin[i], bp_sub[i]), 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    q.delete();
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (6) @(negedge clk);
    send(vecs[1].a, vecs[1].b, vecs[1].cin, vecs[1].sub, vec_exp(vecs[1]), 1'b1);
    drain();

    for (i = 0; i < 5000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++) @(negedge clk);
    check("sweep_finished", {61'd0, g_sw[0].done, g_sw[1].done, g_sw[2].done}, 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_n_pipe.md
# add_n_pipe

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface on both sides. It generalises the fixed 16-bit combinational adder by adding operand width and pipeline depth parameters, carry-in, a subtract mode, status flags and backpressure. It sits between the register file / operand mux and the ALU result path. It sustains one operation per cycle at any WIDTH by breaking the carry chain into STAGES registered chunks.

## Interface
- WIDTH, default 16: operand/result width in bits; must be a multiple of STAGES.
- STAGES, default 4: pipeline depth, at least 1; the chunk width is C = WIDTH/STAGES.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
- overflow  output  1  signed overflow: operand MSBs equal (after the ~b for sub) and the sum MSB differs.
- zero  output  1  sum == 0.

## Operation
- The effective operand is bx = sub ? ~b : b. The effective carry-in is c0 = sub ? 1 : cin.
- Stage k (k = 1..STAGES) adds chunk k-1, bits [(k-1)C +: C], of a and bx plus the carry registered by stage k-1. Stage 1 uses c0.
- Stage k registers:
  - its valid bit;
  - the computed lower k chunks of sum;
  - the carry out of its chunk;
  - the not-yet-added upper chunks of a and bx;
  - the sign bits needed for overflow (a MSB, bx MSB).
- The last stage drives sum and cout directly from registers. Overflow and zero are computed combinationally from the last-stage registers.
- Advance rule (global stall): adv = ~out_valid | out_ready.
  - When adv=1, every stage loads from its predecessor. Stage 1 loads {in_valid, operands}.
  - When adv=0, all stages hold.
- in_ready = adv. A beat is accepted iff in_valid & in_ready at a rising edge.
- Bubbles (valid=0 stages) travel with the pipe and are not collapsed. Results emerge in issue order.
- Data outputs are don't-care when out_valid=0, but they hold stable while out_valid=1 and out_ready=0.
- Arithmetic is unsigned modulo 2^WIDTH. cout and overflow together give both unsigned and signed interpretations.

## Timing
- Reset (asynchronous assert; released synchronously by the environment): all stage valid bits clear to 0.
  - out_valid=0.
  - in_ready=1.
  - sum=0, cout=0, overflow=0.
  - zero=1 (sum register cleared).
- Reset mid-operation discards all in-flight beats. No result for them ever appears.
- Latency: a beat accepted at edge N has out_valid=1 in the cycle following edge N+STAGES-1, i.e. STAGES cycles. STAGES=1 gives a single registered adder.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 forces in_ready=0 combinationally in the same cycle. No beat is lost or duplicated.
- Simultaneous accept and emit in one cycle (full pipe, out_ready=1, in_valid=1) is legal and required.
- in_ready depends combinationally on out_ready. There are no combinational paths from a, b, cin or sub to any output.
- Carry wrap-around: 0xFFFF+0x0001 gives sum=0x0000, cout=1, zero=1, overflow=0.

## Test plan
- Reset, then WIDTH=16, STAGES=4, sub=0, cin=0, back-to-back with out_ready=1:
  - 0x0000+0xFFFF gives 0xFFFF, cout=0.
  - 0x3CC3+0x0FF0 gives 0x4CB3.
  - 0x1234+0x9876 gives 0xAAAA.
  - Results appear on 3 consecutive cycles, the first exactly 4 cycles after the first accept.
- Flags:
  - 0x7FFF+0x0001 gives 0x8000, overflow=1, cout=0.
  - 0xFFFF+0x0001 gives 0x0000, cout=1, zero=1.
  - 0x0000+0x0000 with cin=1 gives 0x0001, zero=0.
- Subtract:
  - 0x0005-0x0007 gives 0xFFFE, cout=0.
  - 0x8000-0x0001 gives 0x7FFF, overflow=1, cout=1.
  - Either subtract with cin=1 gives the same result (cin is ignored).
- Backpressure: stream 8 random beats, hold out_ready=0 for 5 cycles mid-stream.
  - out_valid and the held result stay stable through the stall.
  - in_ready=0 while the stall is in effect.
  - All 8 results arrive in order and match the model, with no duplicates.
- Reset mid-flight: accept 3 beats, assert reset for 1 cycle.
  - out_valid=0 immediately and the 3 beats never emerge.
  - in_ready=1 after reset.
  - The next beat has a 4-cycle latency.
- Parameter sweep: WIDTH=8/STAGES=1, WIDTH=32/STAGES=8 and WIDTH=16/STAGES=16, each with 1000 random beats against the reference model.
  - Latency equals STAGES.
  - sum, cout, overflow and zero are exact on every beat.
